// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector and stall sequencer for a 5-stage MIPS pipeline.
// Freezes PC and IF/ID and injects bubbles on data hazards, flushes IF/ID on taken branches.
module hazard_stall_unit #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_BranchOrJr,
    input  logic             PCSrcTaken,
    input  logic [1:0]       IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_WriteReg,
    input  logic [1:0]       EXMEM_MemRead,
    input  logic [4:0]       EXMEM_WriteReg,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             controlMuxSignal,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic load_ex;
    logic load_mem;
    logic match_ex;
    logic match_mem;
    logic hz2;
    logic hz1;
    logic stall;

    // Register $0 is hardwired to zero and can never carry a dependency.
    function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        load_ex   = (IDEX_MemRead != 2'd0);
        load_mem  = (EXMEM_MemRead != 2'd0);
        match_ex  = src_match(IDEX_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
        match_mem = src_match(EXMEM_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);

        // A load feeding a branch compare needs its data from MEM/WB, two cycles away.
        hz2 = IFID_BranchOrJr && load_ex && match_ex;
        hz1 = (load_ex && match_ex && !hz2)
            || (IFID_BranchOrJr && IDEX_RegWrite && !load_ex && match_ex)
            || (IFID_BranchOrJr && load_mem && match_mem);

        stall   = (state_q == HOLD) || hz1 || hz2;
        state_d = RUN;
        if (!Reset && (state_q == RUN) && hz2) begin
            state_d = HOLD;
        end

        PCWrite          = 1'b0;
        IFIDWrite        = 1'b0;
        controlMuxSignal = 1'b0;
        IFIDFlush        = 1'b0;
        if (!Reset && !stall) begin
            PCWrite          = 1'b1;
            IFIDWrite        = 1'b1;
            controlMuxSignal = 1'b1;
            IFIDFlush        = PCSrcTaken;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= RUN;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state_q <= state_d;
            if (!controlMuxSignal) begin
                StallCount <= sat_inc(StallCount);
            end
            if (IFIDFlush) begin
                FlushCount <= sat_inc(FlushCount);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: per-cycle reference model plus hand-computed checkpoints.
// A second instance with 2-bit counters exercises counter saturation.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs = '0, rt = '0;
    logic        uses_rt = 1'b0, br = 1'b0, taken = 1'b0;
    logic [1:0]  idex_mr = '0;
    logic        idex_rw = 1'b0;
    logic [4:0]  idex_wr = '0;
    logic [1:0]  exmem_mr = '0;
    logic [4:0]  exmem_wr = '0;

    logic        pcw, ifw, flush, cms;
    logic [31:0] sc, fc;
    logic        s_pcw, s_ifw, s_flush, s_cms;
    logic [1:0]  s_sc, s_fc;

    int nvec = 0;
    int nerr = 0;
    bit armed = 1'b0;

    longint m_sc, m_fc, ms_sc, ms_fc;
    int     m_pend;
    localparam longint MAXW = (64'd1 << 32) - 1;
    localparam longint MAXS = 3;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(32)) dut (
        .Clk(clk), .Reset(reset), .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses_rt),
        .IFID_BranchOrJr(br), .PCSrcTaken(taken), .IDEX_MemRead(idex_mr),
        .IDEX_RegWrite(idex_rw), .IDEX_WriteReg(idex_wr), .EXMEM_MemRead(exmem_mr),
        .EXMEM_WriteReg(exmem_wr), .PCWrite(pcw), .IFIDWrite(ifw), .IFIDFlush(flush),
        .controlMuxSignal(cms), .StallCount(sc), .FlushCount(fc)
    );

    hazard_stall_unit #(.CNT_W(2)) dut_sat (
        .Clk(clk), .Reset(reset), .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses_rt),
        .IFID_BranchOrJr(br), .PCSrcTaken(taken), .IDEX_MemRead(idex_mr),
        .IDEX_RegWrite(idex_rw), .IDEX_WriteReg(idex_wr), .EXMEM_MemRead(exmem_mr),
        .EXMEM_WriteReg(exmem_wr), .PCWrite(s_pcw), .IFIDWrite(s_ifw), .IFIDFlush(s_flush),
        .controlMuxSignal(s_cms), .StallCount(s_sc), .FlushCount(s_fc)
    );

    function automatic bit reads(input logic [4:0] r);
        return (r != 0) && (r == rs || (uses_rt && r == rt));
    endfunction

    function automatic longint bump(input longint v, input longint maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a pending-stall count says how many more cycles are forced.
    always @(negedge clk) begin
        if (armed) begin
            bit st, fl;
            int need;
            st = 1'b0;
            fl = 1'b0;
            if (reset) begin
                st = 1'b1;
            end else if (m_pend > 0) begin
                st = 1'b1;
                m_pend--;
            end else begin
                need = 0;
                if (idex_mr != 0 && reads(idex_wr)) need = br ? 2 : 1;
                if (br && idex_rw && idex_mr == 0 && reads(idex_wr) && need == 0) need = 1;
                if (br && exmem_mr != 0 && reads(exmem_wr) && need == 0) need = 1;
                st = (need > 0);
                m_pend = (need > 0) ? need - 1 : 0;
                fl = !st && taken;
            end
            check("pcwrite",  pcw,  (!st) ? 1 : 0);
            check("ifidwrite", ifw, (!st) ? 1 : 0);
            check("ctrlmux",  cms,  (!st) ? 1 : 0);
            check("flush",    flush, fl ? 1 : 0);
            check("stallcnt", sc,   m_sc);
            check("flushcnt", fc,   m_fc);
            check("sat_ctrlmux", s_cms, (!st) ? 1 : 0);
            check("sat_flush",   s_flush, fl ? 1 : 0);
            check("sat_stallcnt", s_sc, ms_sc);
            check("sat_flushcnt", s_fc, ms_fc);
            if (reset) begin
                m_pend = 0; m_sc = 0; m_fc = 0; ms_sc = 0; ms_fc = 0;
            end else begin
                if (st) begin m_sc = bump(m_sc, MAXW); ms_sc = bump(ms_sc, MAXS); end
                if (fl) begin m_fc = bump(m_fc, MAXW); ms_fc = bump(ms_fc, MAXS); end
            end
        end
    end

    task automatic drive(input logic r, input logic [4:0] s, input logic [4:0] t,
                         input logic u, input logic b, input logic k,
                         input logic [1:0] imr, input logic irw, input logic [4:0] iwr,
                         input logic [1:0] emr, input logic [4:0] ewr);
        @(posedge clk);
        #1;
        reset = r; rs = s; rt = t; uses_rt = u; br = b; taken = k;
        idex_mr = imr; idex_rw = irw; idex_wr = iwr; exmem_mr = emr; exmem_wr = ewr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
    endtask

    // Hand-computed checkpoint, sampled 2 time units after the active edge.
    task automatic expect_out(input string nm, input bit run, input bit fl,
                              input longint esc, input longint efc);
        #1;
        check({nm, ".pcwrite"}, pcw, run);
        check({nm, ".ctrlmux"}, cms, run);
        check({nm, ".flush"}, flush, fl);
        check({nm, ".stallcnt"}, sc, esc);
        check({nm, ".flushcnt"}, fc, efc);
    endtask

    initial begin
        @(posedge clk);
        #1;
        m_pend = 0; m_sc = 0; m_fc = 0; ms_sc = 0; ms_fc = 0;
        armed = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
        expect_out("reset", 0, 0, 0, 0);
        idle();
        expect_out("idle0", 1, 0, 0, 0);

        // load-use: lw $8 in EX, add reads $8
        drive(0, 8, 0, 0, 0, 0, 2'd1, 1, 8, 2'd0, 0);
        expect_out("loaduse", 0, 0, 0, 0);
        drive(0, 8, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
        expect_out("loaduse_after", 1, 0, 1, 0);

        // load into branch: two stall cycles, HOLD ignores inputs and PCSrcTaken
        drive(0, 9, 0, 0, 1, 0, 2'd1, 1, 9, 2'd0, 0);
        expect_out("ldbr_run", 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 2'd0, 0);
        expect_out("ldbr_hold", 0, 0, 2, 0);
        drive(0, 9, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0, 0);
        expect_out("ldbr_after", 1, 0, 3, 0);

        // ALU result into jr $31, then $0 never matches
        drive(0, 31, 0, 0, 1, 0, 2'd0, 1, 31, 2'd0, 0);
        expect_out("jr31", 0, 0, 3, 0);
        drive(0, 0, 0, 0, 1, 0, 2'd0, 1, 0, 2'd0, 0);
        expect_out("jr0", 1, 0, 4, 0);

        // rt only counts when the instruction reads it
        drive(0, 0, 5, 0, 0, 0, 2'd1, 1, 5, 2'd0, 0);
        expect_out("rt_unused", 1, 0, 4, 0);
        drive(0, 0, 5, 1, 0, 0, 2'd1, 1, 5, 2'd0, 0);
        expect_out("rt_used", 0, 0, 4, 0);

        // load in MEM feeding a branch: one cycle, then re-evaluated
        drive(0, 3, 0, 0, 1, 0, 2'd0, 0, 0, 2'd2, 3);
        expect_out("memload_br", 0, 0, 5, 0);
        idle();
        expect_out("memload_after", 1, 0, 6, 0);

        // taken branch, no hazard
        drive(0, 4, 0, 0, 1, 1, 2'd0, 0, 0, 2'd0, 0);
        expect_out("taken", 1, 1, 6, 0);
        idle();
        expect_out("taken_after", 1, 0, 6, 1);

        // taken during a stall must not flush
        drive(0, 8, 0, 0, 1, 1, 2'd0, 1, 8, 2'd0, 0);
        expect_out("taken_stall", 0, 0, 6, 1);
        idle();
        expect_out("taken_stall_after", 1, 0, 7, 1);

        // H1 and H2 together: H2 wins, two cycles
        drive(0, 9, 0, 0, 1, 0, 2'd1, 1, 9, 2'd1, 9);
        expect_out("h1h2_run", 0, 0, 7, 1);
        idle();
        expect_out("h1h2_hold", 0, 0, 8, 1);
        idle();
        expect_out("h1h2_after", 1, 0, 9, 1);

        // reset while in HOLD
        drive(0, 9, 0, 0, 1, 0, 2'd1, 1, 9, 2'd0, 0);
        expect_out("rsthold_run", 0, 0, 9, 1);
        drive(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
        expect_out("rsthold_rst", 0, 0, 10, 1);
        idle();
        expect_out("rsthold_after", 1, 0, 0, 0);

        // saturation on the 2-bit instance
        repeat (6) drive(0, 8, 0, 0, 0, 0, 2'd1, 1, 8, 2'd0, 0);
        idle();
        expect_out("sat_run", 1, 0, 6, 0);
        check("sat.stallcnt", s_sc, 3);
        repeat (4) drive(0, 1, 0, 0, 1, 1, 2'd0, 0, 0, 2'd0, 0);
        idle();
        expect_out("satf_run", 1, 0, 6, 4);
        check("sat.flushcnt", s_fc, 3);
        idle();

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
